instr_fetch: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter block. Each cycle it takes the current PC value and issues a word read to instruction memory over a request/grant port. It captures the returned instruction with its PC into a small FIFO and presents it to decode over a valid/ready handshake. It also drives `pc_hold` back to the PC block and discards stale fetches when a taken branch (`pc_src`) redirects the PC.

---
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read at a time.
// Returned words are queued with their PC for decode; a redirect flushes the queue and kills an in-flight fetch.
module instr_fetch #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  output logic            pc_hold,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            dec_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] req_pc;
  entry_t          fifo [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            push, pop;

  // Gating on count is what guarantees a push never lands on a full queue.
  assign imem_req  = (state == S_REQ) && (count < DEPTH_C) && !pc_src && !reset;
  assign imem_addr = pc;
  assign pc_hold   = !(imem_req && imem_gnt) && !pc_src;

  assign push     = (state == S_WAIT) && imem_rvalid && !pc_src;
  assign if_valid = (count != '0);
  assign pop      = if_valid && dec_ready && !pc_src;
  assign if_instr = if_valid ? fifo[rptr].instr : '0;
  assign if_pc    = if_valid ? fifo[rptr].pc    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_REQ;
      req_pc <= '0;
    end else begin
      case (state)
        S_REQ: if (imem_req && imem_gnt) begin
          req_pc <= pc;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid)  state <= S_REQ;
          else if (pc_src)  state <= S_KILL;
        end
        // Stale response still owed by memory; swallow it before refetching.
        S_KILL: if (imem_rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= '{pc: req_pc, instr: imem_rdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (pc_src) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC-block and memory models around the DUT, scoreboard on decode pops.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        pc_src = 1'b0;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        dec_ready = 1'b0;

  logic [31:0] br_target = 32'h0;
  int          lat = 1;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          first_pop = 0;
  int          last_pop = 0;
  logic        mon_en = 1'b0;
  logic [63:0] exp_q [$];

  logic        pend;
  int          dcnt;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_src(pc_src), .pc_hold(pc_hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .dec_ready(dec_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // PC block: advances by 4 on an accepted fetch, loads the target on a redirect.
  always @(posedge clk or posedge reset) begin
    if (reset)         pc <= 32'h0;
    else if (pc_src)   pc <= br_target;
    else if (!pc_hold) pc <= pc + 32'h4;
  end

  // Memory: always grants, answers `lat` cycles after the grant.
  assign imem_gnt    = 1'b1;
  assign imem_rvalid = pend && (dcnt == 0);
  assign imem_rdata  = imem_rvalid ? (paddr ^ 32'hA5A5_0000) : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= 1'b0;
      dcnt  <= 0;
      paddr <= 32'h0;
    end else begin
      if (imem_rvalid) pend <= 1'b0;
      if (imem_req && imem_gnt) begin
        pend  <= 1'b1;
        dcnt  <= lat - 1;
        paddr <= imem_addr;
      end else if (pend && dcnt != 0) begin
        dcnt <= dcnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({p, p ^ 32'hA5A5_0000});
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && if_valid && dec_ready && !pc_src && !reset) begin
        pop_cnt++;
        if (pop_cnt == 1) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", if_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", if_pc, e[63:32]);
          check("pop_instr", if_instr, e[31:0]);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 1'b0; dec_ready = 1'b0; pc_src = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
  endtask

  task automatic start(input logic rdy);
    pop_cnt = 0;
    dec_ready = rdy;
    mon_en = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    #1; mon_en = 1'b0; dec_ready = 1'b0;
  endtask

  // Returns at the negedge of the cycle in which the fetch of `a` is granted.
  task automatic wait_grant(input logic [31:0] a, input string name);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk); n++;
      hit = imem_req && imem_gnt && (imem_addr == a);
    end
    check(name, {31'b0, hit}, 32'h1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #2;
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_pc_hold", {31'b0, pc_hold}, 32'h1);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);

    // Free run, zero-wait memory: one instruction per 2 cycles.
    lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    start(1'b1);
    wait_empty("freerun_drain");
    check("freerun_pops", pop_cnt, 8);
    check("freerun_spacing", last_pop - first_pop, 14);

    // Backpressure: queue fills with 0x0 and 0x4, PC frozen at 0x8.
    do_reset();
    start(1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("full_imem_req", {31'b0, imem_req}, 32'h0);
    check("full_pc_hold", {31'b0, pc_hold}, 32'h1);
    check("full_pc", pc, 32'h8);
    check("full_if_pc", if_pc, 32'h0);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    @(posedge clk); #1;
    dec_ready = 1'b1;
    @(negedge clk);
    check("drain0_imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    check("drain1_imem_req", {31'b0, imem_req}, 32'h1);
    check("drain1_imem_addr", imem_addr, 32'h8);
    wait_empty("bp_drain");

    // Redirect while waiting on a 2-cycle response for 0x8: KILL path.
    lat = 2;
    do_reset();
    expect_pc(32'h0); expect_pc(32'h4);
    start(1'b1);
    wait_grant(32'h8, "kill_grant8");
    @(posedge clk); #1;
    pc_src = 1'b1; br_target = 32'h18;
    @(negedge clk);
    check("kill_redirect_req", {31'b0, imem_req}, 32'h0);
    check("kill_redirect_hold", {31'b0, pc_hold}, 32'h0);
    @(posedge clk); #1;
    pc_src = 1'b0;
    @(negedge clk);
    check("kill_if_valid", {31'b0, if_valid}, 32'h0);
    check("kill_imem_req", {31'b0, imem_req}, 32'h0);
    check("kill_rvalid", {31'b0, imem_rvalid}, 32'h1);
    @(negedge clk);
    check("kill_refetch_req", {31'b0, imem_req}, 32'h1);
    check("kill_refetch_addr", imem_addr, 32'h18);
    expect_pc(32'h18); expect_pc(32'h1C);
    wait_empty("kill_drain");

    // Redirect coinciding with the response in WAIT.
    lat = 1;
    do_reset();
    expect_pc(32'h0); expect_pc(32'h4);
    start(1'b1);
    wait_grant(32'h8, "coinc_grant8");
    @(posedge clk); #1;
    pc_src = 1'b1; br_target = 32'h40;
    @(negedge clk);
    check("coinc_rvalid", {31'b0, imem_rvalid}, 32'h1);
    @(posedge clk); #1;
    pc_src = 1'b0;
    @(negedge clk);
    check("coinc_if_valid", {31'b0, if_valid}, 32'h0);
    check("coinc_req", {31'b0, imem_req}, 32'h1);
    check("coinc_addr", imem_addr, 32'h40);
    expect_pc(32'h40); expect_pc(32'h44);
    wait_empty("coinc_drain");

    // Redirect with full queue and decode ready in the same cycle.
    do_reset();
    start(1'b0);
    repeat (10) @(posedge clk);
    #1;
    dec_ready = 1'b1; pc_src = 1'b1; br_target = 32'h80;
    @(negedge clk);
    check("fullsrc_if_valid_before", {31'b0, if_valid}, 32'h1);
    check("fullsrc_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1;
    pc_src = 1'b0;
    @(negedge clk);
    check("fullsrc_if_valid", {31'b0, if_valid}, 32'h0);
    check("fullsrc_if_pc", if_pc, 32'h0);
    check("fullsrc_next_addr", imem_addr, 32'h80);
    expect_pc(32'h80); expect_pc(32'h84);
    wait_empty("fullsrc_drain");

    // Async reset mid-cycle while waiting on a response.
    lat = 2;
    do_reset();
    expect_pc(32'h0); expect_pc(32'h4);
    start(1'b1);
    wait_grant(32'h8, "arst_grant8");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("arst_imem_req", {31'b0, imem_req}, 32'h0);
    check("arst_pc_hold", {31'b0, pc_hold}, 32'h1);
    check("arst_if_valid", {31'b0, if_valid}, 32'h0);
    check("arst_if_pc", if_pc, 32'h0);
    check("arst_pc", pc, 32'h0);
    check("arst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    pop_cnt = 0;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    wait_empty("arst_restart_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
